// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control path:
// FSM states, opcodes, immediate formats and datapath mux selects.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_MEM_ADDR,
    S_LOAD_REQ,
    S_LOAD_WB,
    S_STORE_REQ,
    S_BRANCH,
    S_JAL,
    S_JALR,
    S_LUI,
    S_TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [2:0] {
    IMM_I  = 3'd0,
    IMM_S  = 3'd1,
    IMM_SB = 3'd2,
    IMM_U  = 3'd3,
    IMM_UJ = 3'd4
  } imm_type_e;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JALR   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;
  localparam logic [1:0] WB_IMM    = 2'd3;

  localparam logic [1:0] A_PC    = 2'd0;
  localparam logic [1:0] A_RS1   = 2'd1;
  localparam logic [1:0] A_OLDPC = 2'd2;

  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_FOUR = 2'd1;
  localparam logic [1:0] B_IMM  = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_CMP   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  function automatic logic is_req(input state_e s);
    return (s == S_FETCH) || (s == S_LOAD_REQ) ||
           (s == S_STORE_REQ);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts unacknowledged memory-request cycles and flags
// the cycle in which the wait limit is exhausted.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Ready in the final allowed cycle still wins.
  assign expired = !ready && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (!ready && cnt_q != LAST) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the 64-bit multicycle RISC-V core.
// Optional PERF_COUNTERS_EN adds cycle/instret counters.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_instr,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_type,
  output logic       halted,
  output logic       mem_fault,
  output logic       illegal
`ifdef PERF_COUNTERS_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  state_e state_q, state_d;
  logic   mem_fault_q, illegal_q;
  logic   expired, tmr_start;

  // br_taken is consumed by the datapath through pc_write_cond.
  logic   unused_br;
  assign unused_br = br_taken;

  assign tmr_start = is_req(state_d) && (state_d != state_q);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .CNT_W     (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (tmr_start),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (expired) state_d = S_TRAP;
      end
      S_DECODE: begin
        unique case (1'b1)
          (opcode == OP_R):      state_d = S_EXEC_R;
          (opcode == OP_IMM):    state_d = S_EXEC_I;
          (opcode == OP_LOAD),
          (opcode == OP_STORE):  state_d = S_MEM_ADDR;
          (opcode == OP_BRANCH): state_d = S_BRANCH;
          (opcode == OP_JALR && funct3 == 3'b000):
                                 state_d = S_JALR;
          (opcode == OP_JALR && funct3 != 3'b000):
                                 state_d = S_BRANCH;
          (opcode == OP_JAL):    state_d = S_JAL;
          (opcode == OP_LUI):    state_d = S_LUI;
          default:               state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR: begin
        state_d = (opcode == OP_STORE) ? S_STORE_REQ
                                       : S_LOAD_REQ;
      end
      S_LOAD_REQ: begin
        if (mem_ready)    state_d = S_LOAD_WB;
        else if (expired) state_d = S_TRAP;
      end
      S_STORE_REQ: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (expired) state_d = S_TRAP;
      end
      S_ALU_WB, S_LOAD_WB, S_BRANCH,
      S_JAL, S_JALR, S_LUI: state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      mem_fault_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (is_req(state_q) && state_d == S_TRAP)
        mem_fault_q <= 1'b1;
      if (state_q == S_DECODE && state_d == S_TRAP)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    mem_instr     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = PC_ALU;
    reg_write     = 1'b0;
    wb_sel        = WB_ALUOUT;
    alu_src_a     = A_PC;
    alu_src_b     = B_RS2;
    alu_op        = ALU_ADD;
    imm_type      = IMM_I;
    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        mem_instr = 1'b1;
        alu_src_b = B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        imm_type  = IMM_SB;
      end
      S_EXEC_R: begin
        alu_src_a = A_RS1;
        alu_op    = ALU_FUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        alu_op    = ALU_FUNCT;
      end
      S_ALU_WB: reg_write = 1'b1;
      S_MEM_ADDR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        imm_type  = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      S_LOAD_REQ: mem_req = 1'b1;
      S_LOAD_WB: begin
        reg_write = 1'b1;
        wb_sel    = WB_MDR;
      end
      S_STORE_REQ: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = A_RS1;
        alu_op        = ALU_CMP;
        pc_write_cond = 1'b1;
        pc_src        = PC_ALUOUT;
      end
      S_JAL: begin
        imm_type  = IMM_UJ;
        alu_src_a = A_OLDPC;
        alu_src_b = B_IMM;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a = A_RS1;
        alu_src_b = B_IMM;
        reg_write = 1'b1;
        wb_sel    = WB_PC;
        pc_write  = 1'b1;
        pc_src    = PC_JALR;
      end
      S_LUI: begin
        imm_type  = IMM_U;
        reg_write = 1'b1;
        wb_sel    = WB_IMM;
      end
      default: ;
    endcase
  end

  assign halted    = (state_q == S_TRAP);
  assign mem_fault = mem_fault_q;
  assign illegal   = illegal_q;

`ifdef PERF_COUNTERS_EN
  logic [63:0] cyc_q, ret_q;
  logic        retire;

  assign retire = (state_d == S_FETCH) && (state_q != S_IDLE) &&
                  (state_q != S_FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      if (state_q != S_TRAP) cyc_q <= cyc_q + 64'd1;
      if (retire)            ret_q <= ret_q + 64'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control.
// Walks R/load/store/branch/jump/LUI, timeout and illegal traps.
module tb_multicycle_control;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD_OP  = 7'b0000011;
  localparam logic [6:0] ST_OP  = 7'b0100011;
  localparam logic [6:0] JR_OP  = 7'b1100111;
  localparam logic [6:0] JAL_OP = 7'b1101111;
  localparam logic [6:0] LUI_OP = 7'b0110111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       br_taken;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_instr;
  logic       ir_write, pc_write, pc_write_cond;
  logic [1:0] pc_src, wb_sel, alu_src_a, alu_src_b, alu_op;
  logic       reg_write;
  logic [2:0] imm_type;
  logic       halted, mem_fault, illegal;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.WAIT_LIMIT(15), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .funct3       (funct3),
    .br_taken     (br_taken),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_instr    (mem_instr),
    .ir_write     (ir_write),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .pc_src       (pc_src),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .alu_op       (alu_op),
    .imm_type     (imm_type),
    .halted       (halted),
    .mem_fault    (mem_fault),
    .illegal      (illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; funct3 = '0;
    br_taken = 1'b0; mem_ready = 1'b0;
    #12;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    chk("rst_imm", 32'(imm_type), 0);
    rst_n = 1'b1;
    #1;
    chk("idle_mem_req", 32'(mem_req), 0);
    tick();
    chk("fetch_req", 32'(mem_req), 1);
    chk("fetch_instr", 32'(mem_instr), 1);
    chk("fetch_b", 32'(alu_src_b), 1);
    chk("fetch_irw_wait", 32'(ir_write), 0);

    // R-type, zero-wait memory
    mem_ready = 1'b1; opcode = R_OP; #1;
    chk("fetch_irw", 32'(ir_write), 1);
    chk("fetch_pcw", 32'(pc_write), 1);
    chk("fetch_pcsrc", 32'(pc_src), 0);
    tick();
    chk("dec_a", 32'(alu_src_a), 2);
    chk("dec_b", 32'(alu_src_b), 2);
    chk("dec_imm", 32'(imm_type), 2);
    chk("dec_req", 32'(mem_req), 0);
    tick();
    chk("execr_a", 32'(alu_src_a), 1);
    chk("execr_b", 32'(alu_src_b), 0);
    chk("execr_op", 32'(alu_op), 2);
    chk("execr_rw", 32'(reg_write), 0);
    tick();
    chk("aluwb_rw", 32'(reg_write), 1);
    chk("aluwb_wb", 32'(wb_sel), 0);
    tick();
    chk("r_back_fetch", 32'(mem_req), 1);
    chk("r_back_rw", 32'(reg_write), 0);

    // Load with three wait cycles
    opcode = LD_OP;
    tick();
    tick();
    chk("ld_addr_imm", 32'(imm_type), 0);
    chk("ld_addr_a", 32'(alu_src_a), 1);
    chk("ld_addr_b", 32'(alu_src_b), 2);
    chk("ld_addr_req", 32'(mem_req), 0);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1'b1;
      #1;
      chk("ld_req_held", 32'(mem_req), 1);
      chk("ld_req_we", 32'(mem_we), 0);
      chk("ld_req_instr", 32'(mem_instr), 0);
      tick();
    end
    chk("ldwb_rw", 32'(reg_write), 1);
    chk("ldwb_wb", 32'(wb_sel), 1);
    chk("ldwb_req", 32'(mem_req), 0);
    tick();
    chk("ld_back_fetch", 32'(mem_instr), 1);

    // Branch via 1100111/funct3=001, taken then not taken
    for (int t = 1; t >= 0; t--) begin
      opcode = JR_OP; funct3 = 3'b001;
      tick();
      chk("br_dec_imm", 32'(imm_type), 2);
      tick();
      br_taken = t[0]; #1;
      chk("br_pcwc", 32'(pc_write_cond), 1);
      chk("br_pcsrc", 32'(pc_src), 1);
      chk("br_op", 32'(alu_op), 1);
      chk("br_pcw", 32'(pc_write), 0);
      tick();
      chk("br_back_fetch", 32'(mem_req), 1);
    end

    // JALR
    funct3 = 3'b000;
    tick();
    tick();
    chk("jalr_pcsrc", 32'(pc_src), 2);
    chk("jalr_pcw", 32'(pc_write), 1);
    chk("jalr_wb", 32'(wb_sel), 2);
    chk("jalr_imm", 32'(imm_type), 0);
    chk("jalr_a", 32'(alu_src_a), 1);
    tick();

    // JAL
    opcode = JAL_OP;
    tick();
    tick();
    chk("jal_imm", 32'(imm_type), 4);
    chk("jal_a", 32'(alu_src_a), 2);
    chk("jal_rw", 32'(reg_write), 1);
    chk("jal_pcsrc", 32'(pc_src), 0);
    tick();

    // LUI
    opcode = LUI_OP;
    tick();
    tick();
    chk("lui_imm", 32'(imm_type), 3);
    chk("lui_wb", 32'(wb_sel), 3);
    chk("lui_rw", 32'(reg_write), 1);
    tick();

    // I-type
    opcode = I_OP;
    tick();
    tick();
    chk("execi_imm", 32'(imm_type), 0);
    chk("execi_b", 32'(alu_src_b), 2);
    chk("execi_op", 32'(alu_op), 2);
    tick();
    tick();
    chk("i_back_fetch", 32'(mem_req), 1);

    // Fetch timeout: never ready
    mem_ready = 1'b0;
    do_reset();
    tick();
    for (int i = 1; i < 15; i++) tick();
    chk("to_cycle15_req", 32'(mem_req), 1);
    chk("to_cycle15_halt", 32'(halted), 0);
    tick();
    chk("to_halted", 32'(halted), 1);
    chk("to_fault", 32'(mem_fault), 1);
    chk("to_illegal", 32'(illegal), 0);
    chk("to_req", 32'(mem_req), 0);

    // Ready on the 15th wait cycle: no trap
    do_reset();
    chk("rst_fault_clr", 32'(mem_fault), 0);
    tick();
    for (int i = 1; i < 15; i++) tick();
    mem_ready = 1'b1; opcode = 7'h7f; #1;
    chk("late_irw", 32'(ir_write), 1);
    tick();
    chk("late_halt", 32'(halted), 0);
    chk("late_dec_a", 32'(alu_src_a), 2);
    chk("late_fault", 32'(mem_fault), 0);

    // Illegal opcode
    tick();
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_halt", 32'(halted), 1);
    chk("ill_fault", 32'(mem_fault), 0);
    for (int i = 0; i < 20; i++) begin
      mem_ready = i[0];
      tick();
      chk("ill_req_idle", 32'(mem_req), 0);
    end
    do_reset();
    chk("ill_clr", 32'(illegal), 0);
    chk("ill_halt_clr", 32'(halted), 0);

    // Reset in the middle of a store
    mem_ready = 1'b0;
    tick();
    mem_ready = 1'b1; opcode = ST_OP;
    tick();
    tick();
    chk("st_addr_imm", 32'(imm_type), 1);
    mem_ready = 1'b0;
    tick();
    chk("st_req", 32'(mem_req), 1);
    chk("st_we", 32'(mem_we), 1);
    chk("st_instr", 32'(mem_instr), 0);
    rst_n = 1'b0;
    #1;
    chk("st_rst_req", 32'(mem_req), 0);
    chk("st_rst_we", 32'(mem_we), 0);
    chk("st_rst_rw", 32'(reg_write), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("st_idle_req", 32'(mem_req), 0);
    tick();
    chk("st_fetch_req", 32'(mem_req), 1);
    chk("st_fetch_instr", 32'(mem_instr), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the 64-bit multicycle RISC-V core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file, PC/IR registers and unified memory port.
- Drives the immediate-type select used by the sign-extension unit, the datapath mux selects and the write enables.
- Handles a ready-based memory handshake with timeout trap.

Parameters:
- WAIT_LIMIT, 15, max cycles a memory request may stay unacknowledged before trapping (1..255).
- CNT_W, 8, width of wait counter; must hold WAIT_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- br_taken  in  1  branch condition from ALU compare, valid in BRANCH state.
- mem_ready  in  1  memory completion strobe for the current request.
- mem_req  out  1  memory request, held until mem_ready.
- mem_we  out  1  1 = store, 0 = read; valid with mem_req.
- mem_instr  out  1  1 = instruction fetch address (PC), 0 = data address (ALUOut).
- ir_write  out  1  load IR.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load gated by br_taken.
- pc_src  out  2  0 ALU result, 1 ALUOut, 2 ALU result with bit0 cleared (jalr).
- reg_write  out  1  register-file write.
- wb_sel  out  2  0 ALUOut, 1 MDR, 2 PC (link), 3 immediate.
- alu_src_a  out  2  0 PC, 1 rs1, 2 old PC.
- alu_src_b  out  2  0 rs2, 1 constant 4, 2 immediate.
- alu_op  out  2  0 add, 1 compare/branch, 2 decode funct fields.
- imm_type  out  3  immediate format select.
- halted  out  1  FSM in TRAP.
- mem_fault  out  1  sticky; timeout caused the trap.
- illegal  out  1  sticky; unsupported opcode caused the trap.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, all outputs 0, sticky flags cleared. Reset mid-instruction abandons it immediately; no partial writes after reset.
- All outputs are Moore: decoded from the registered state. The only exception is ir_write and pc_write in FETCH, which assert only in the cycle mem_ready=1.
- IDLE -> FETCH unconditionally, one cycle after reset release.
- FETCH:
  - mem_req=1, mem_instr=1, alu_src_a=0, alu_src_b=1, alu_op=0.
  - Hold until mem_ready.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0 (PC+4), -> DECODE.
- DECODE: alu_src_a=2, alu_src_b=2, imm_type=SB (branch target precomputed to ALUOut). Next state by opcode:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 / 0100011 -> MEM_ADDR
  - 1100011 -> BRANCH
  - 1100111 with funct3=000 -> JALR
  - 1100111 with funct3!=000 -> BRANCH
  - 1101111 -> JAL
  - 0110111 -> LUI
  - anything else -> TRAP with illegal=1
- EXEC_R: a=1, b=0, alu_op=2 -> ALU_WB.
- EXEC_I: a=1, b=2, imm_type=I, alu_op=2 -> ALU_WB.
- ALU_WB: reg_write=1, wb_sel=0 -> FETCH.
- MEM_ADDR: a=1, b=2, alu_op=0; imm_type=I for loads, S for stores. Loads -> LOAD_REQ, stores -> STORE_REQ.
- LOAD_REQ: mem_req=1, mem_we=0; on mem_ready -> LOAD_WB.
- LOAD_WB: reg_write=1, wb_sel=1 -> FETCH.
- STORE_REQ: mem_req=1, mem_we=1; on mem_ready -> FETCH.
- BRANCH: a=1, b=0, alu_op=1, pc_write_cond=1, pc_src=1 -> FETCH.
- JAL:
  - imm_type=UJ, a=2, b=2; reg_write=1, wb_sel=2; pc_write=1, pc_src=0 -> FETCH.
  - DECODE already computed the SB-format target; the ALU recomputes with the UJ format here.
- JALR: imm_type=I, a=1, b=2, reg_write=1, wb_sel=2, pc_write=1, pc_src=2 -> FETCH.
- LUI: imm_type=U, reg_write=1, wb_sel=3 -> FETCH.
- Latency with zero-wait memory:
  - R/I/LUI/JAL/JALR/BRANCH: 4/4/3/3/3/3 cycles.
  - Load: 5 cycles. Store: 4 cycles.
  - Each memory wait cycle adds one.
- Wait counter:
  - Clears on entry to FETCH, LOAD_REQ or STORE_REQ; increments each cycle without mem_ready.
  - If it reaches WAIT_LIMIT with mem_ready still 0 -> TRAP, mem_fault=1.
  - mem_ready in the same cycle the counter hits the limit counts as success.
- TRAP: halted=1, all enables and mem_req 0. Exits only via reset.
- mem_ready outside a request state is ignored.

Optional Feature:
- Macro PERF_COUNTERS_EN.
- When defined: adds outputs cycle_cnt [63:0] and instret_cnt [63:0], both reset to 0.
  - cycle_cnt increments every cycle while not halted.
  - instret_cnt increments on every transition into FETCH from a completion state (not from IDLE). Both wrap at 2^64.
- When undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package ctrl_pkg holds:
  - state enum;
  - opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_LUI);
  - imm_type enum: I=0, S=1, SB=2, U=3, UJ=4;
  - pc_src, wb_sel, alu_src and alu_op encodings.
- One sub-module, mem_wait_timer: counter plus timeout compare, inputs start/ready, output expired.

Test Plan:
- R-type (opcode 0110011), mem_ready tied 1 -> states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 exactly in cycle 4; back in FETCH in cycle 5.
- Load with mem_ready delayed 3 cycles in LOAD_REQ -> mem_req held 4 cycles, mem_we=0, LOAD_WB with wb_sel=1 one cycle after ready.
- Branch (1100111, funct3=001) with br_taken=1, then with br_taken=0 -> imm_type=SB in DECODE, pc_write_cond=1 in BRANCH both times, pc_src=1.
- Opcode 1111111 -> TRAP after DECODE; illegal=1, halted=1; mem_req stays 0 for 20 cycles; rst_n pulse clears all flags.
- Fetch with mem_ready never asserted, WAIT_LIMIT=15 -> TRAP after 15 wait cycles, mem_fault=1; repeat with ready on the 15th cycle -> no trap.
- rst_n dropped mid-STORE_REQ -> all outputs 0 asynchronously; state IDLE, then FETCH one cycle after release.
